// File: rtl/instr_mem_prog.sv
// Reloadable instruction memory: registered fetch port, byte-stream loader and NOP clear engine.
// Array power-up contents are undefined; preload it through the load port or a clear.
module instr_mem_prog #(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    DEPTH_LOG2 = 8,
  parameter logic [DATA_WIDTH-1:0] NOP_WORD   = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rd_en,
  input  logic [31:0]           addr,
  output logic [DATA_WIDTH-1:0] instr,
  output logic                  addr_err,
  input  logic                  ld_start,
  input  logic                  ld_valid,
  input  logic [7:0]            ld_byte,
  input  logic                  ld_end,
  output logic                  ld_ready,
  input  logic                  clr,
  output logic                  busy,
  output logic [DEPTH_LOG2:0]   ld_count,
  output logic                  ld_overflow
);

  localparam int BYTE_LANES = DATA_WIDTH / 8;
  localparam int DEPTH      = 1 << DEPTH_LOG2;
  localparam int PTR_W      = DEPTH_LOG2 + 1;
  localparam int LANE_W     = (BYTE_LANES > 1) ? $clog2(BYTE_LANES) : 1;
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(BYTE_LANES - 1);

  typedef enum logic [1:0] {IDLE, LOAD, CLEAR} state_t;

  state_t                  state, state_n;
  logic [PTR_W-1:0]        ptr;
  logic [LANE_W-1:0]       lane, lane_n;
  logic [DATA_WIDTH-1:0]   word_buf, asm_word, wdata;
  logic                    accept, full, we, err;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  assign full     = (ptr == PTR_W'(DEPTH));
  assign busy     = (state != IDLE);
  assign ld_ready = (state == LOAD) && !full;
  assign err      = (addr[1:0] != 2'b00) || (addr[31:DEPTH_LOG2+2] != '0);

  // Next state and write port; a partial word starts from zero so unfilled upper lanes read 0.
  always_comb begin
    state_n  = state;
    accept   = 1'b0;
    asm_word = (lane == '0) ? '0 : word_buf;
    lane_n   = lane;
    we       = 1'b0;
    wdata    = NOP_WORD;
    case (state)
      IDLE: begin
        if (clr)
          state_n = CLEAR;
        else if (ld_start)
          state_n = LOAD;
      end
      LOAD: begin
        accept = ld_valid && !full;
        if (accept) begin
          for (int i = 0; i < BYTE_LANES; i++)
            if (lane == LANE_W'(i))
              asm_word[i*8 +: 8] = ld_byte;
          if (lane == LAST_LANE) begin
            lane_n = '0;
            we     = 1'b1;
          end else begin
            lane_n = lane + LANE_W'(1);
          end
        end
        if (ld_end) begin
          if (lane_n != '0)
            we = 1'b1;
          state_n = IDLE;
        end
        wdata = asm_word;
      end
      CLEAR: begin
        we = 1'b1;
        if (ptr == PTR_W'(DEPTH - 1))
          state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Array is never reset so a loaded program survives a CPU reset.
  always_ff @(posedge clk) begin
    if (we && !reset)
      mem[ptr[DEPTH_LOG2-1:0]] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      instr       <= NOP_WORD;
      addr_err    <= 1'b0;
      ptr         <= '0;
      lane        <= '0;
      word_buf    <= '0;
      ld_count    <= '0;
      ld_overflow <= 1'b0;
    end else begin
      state <= state_n;
      case (state)
        IDLE: begin
          if (clr || ld_start) begin
            instr    <= NOP_WORD;
            addr_err <= 1'b0;
            ptr      <= '0;
            if (!clr) begin
              lane        <= '0;
              word_buf    <= '0;
              ld_count    <= '0;
              ld_overflow <= 1'b0;
            end
          end else if (rd_en) begin
            instr    <= err ? NOP_WORD : mem[addr[DEPTH_LOG2+1:2]];
            addr_err <= err;
          end
        end
        LOAD: begin
          instr    <= NOP_WORD;
          addr_err <= 1'b0;
          lane     <= ld_end ? '0 : lane_n;
          if (accept)
            word_buf <= asm_word;
          if (ld_valid && full)
            ld_overflow <= 1'b1;
          if (we) begin
            ptr      <= ptr + PTR_W'(1);
            ld_count <= ld_count + PTR_W'(1);
          end
        end
        CLEAR: begin
          instr    <= NOP_WORD;
          addr_err <= 1'b0;
          ptr      <= ptr + PTR_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule
